alu_op_sequencer: RTL and testbench

- Multi-cycle controller that sequences the register-file/ALU datapath.
- Accepts register-to-register commands (op, srcA, srcB, dest) over a valid/ready handshake into a small FIFO.
- Per command: drives register read addresses, then the ALU control word, then a one-cycle register write-back, and latches the ALU flags.
- Sits between the command source (future decoder or bench) and the existing regfile + ALU.

---
 rtl/alu_op_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command FIFO feeding a READ/EXEC/WRITE sequencer for the regfile/ALU datapath; define ALU_SEQ_OP_COUNT_EN to add a saturating op_count output
module alu_op_sequencer #(
    parameter int REG_ADDR_BITS = 3,
    parameter int CMD_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [REG_ADDR_BITS-1:0] cmd_src_a,
    input  logic [REG_ADDR_BITS-1:0] cmd_src_b,
    input  logic [REG_ADDR_BITS-1:0] cmd_dest,
    output logic [REG_ADDR_BITS-1:0] reg_addr_a,
    output logic [REG_ADDR_BITS-1:0] reg_addr_b,
    output logic [3:0]               alu_control,
    output logic                     reg_write_en,
    output logic [REG_ADDR_BITS-1:0] reg_write_addr,
    input  logic                     alu_carry,
    input  logic                     alu_low,
    input  logic                     alu_overflow,
    input  logic                     alu_neg,
    input  logic                     alu_zero,
    output logic [4:0]               flags,
    output logic                     busy,
    output logic                     done_pulse,
`ifdef ALU_SEQ_OP_COUNT_EN
    output logic                     illegal_op,
    output logic [15:0]              op_count
`else
    output logic                     illegal_op
`endif
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int EW = 4 + 3 * REG_ADDR_BITS;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_LAST = 4'd8;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [EW-1:0]            r_fifo [CMD_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW:0]              r_count;
    logic [3:0]               r_op;
    logic [3:0]               r_alu_ctl;
    logic [REG_ADDR_BITS-1:0] r_src_a;
    logic [REG_ADDR_BITS-1:0] r_src_b;
    logic [REG_ADDR_BITS-1:0] r_dest;
    logic [REG_ADDR_BITS-1:0] r_wr_addr;
    logic [4:0]               r_flags;
    logic                     r_illegal;
    logic [EW-1:0]            w_head;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_legal;

    assign reg_addr_a     = r_src_a;
    assign reg_addr_b     = r_src_b;
    assign alu_control    = r_alu_ctl;
    assign reg_write_addr = r_wr_addr;
    assign flags          = r_flags;
    assign illegal_op     = r_illegal;

    // Handshake, pop decision, next state and per-state strobes
    always_comb begin
        cmd_ready    = r_count != (PW+1)'(CMD_DEPTH);
        w_push       = cmd_valid && cmd_ready;
        w_pop        = (r_state == IDLE || r_state == WRITE) && r_count != '0;
        w_head       = r_fifo[r_rd_ptr];
        w_legal      = w_head[EW-1 -: 4] <= OP_LAST;
        w_next       = r_state == READ ? EXEC : r_state == EXEC ? WRITE : (w_pop && w_legal) ? READ : IDLE;
        reg_write_en = r_state == WRITE && r_op != OP_CMP;
        done_pulse   = r_state == WRITE;
        busy         = r_state != IDLE || r_count != '0;
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {cmd_op, cmd_src_a, cmd_src_b, cmd_dest};
    end

    // State register and FIFO pointers, wrapping naturally at the power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_next;
            r_wr_ptr <= w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + PW'(1) : r_rd_ptr;
            r_count  <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Current command, staged ALU control and write address, flag latch, illegal pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op      <= '0;
            r_src_a   <= '0;
            r_src_b   <= '0;
            r_dest    <= '0;
            r_alu_ctl <= '0;
            r_wr_addr <= '0;
            r_flags   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_pop && !w_legal;
            if (w_pop && w_legal) {r_op, r_src_a, r_src_b, r_dest} <= w_head;
            if (r_state == READ) r_alu_ctl <= r_op;
            if (r_state == EXEC && r_op != OP_CMP) r_wr_addr <= r_dest;
            if (r_state == WRITE) r_flags <= {alu_carry, alu_low, alu_overflow, alu_neg, alu_zero};
        end
    end

`ifdef ALU_SEQ_OP_COUNT_EN
    logic [15:0] r_op_count;

    assign op_count = r_op_count;

    // Completed legal commands, saturating at all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_op_count <= '0;
        else if (done_pulse && r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: regfile/ALU environment around the sequencer, vector table, directed corner sequences and a random scoreboard
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [2:0]  cmd_src_a = '0;
    logic [2:0]  cmd_src_b = '0;
    logic [2:0]  cmd_dest = '0;
    logic [2:0]  reg_addr_a;
    logic [2:0]  reg_addr_b;
    logic [3:0]  alu_control;
    logic        reg_write_en;
    logic [2:0]  reg_write_addr;
    logic        alu_carry;
    logic        alu_low;
    logic        alu_overflow;
    logic        alu_neg;
    logic        alu_zero;
    logic [4:0]  flags;
    logic        busy;
    logic        done_pulse;
    logic        illegal_op;
`ifdef ALU_SEQ_OP_COUNT_EN
    logic [15:0] op_count;
`endif

    typedef struct {logic [3:0] op; logic [2:0] a; logic [2:0] b; logic [2:0] d;} cmd_t;
    typedef struct {logic [3:0] op; logic [2:0] a; logic [2:0] b; logic [2:0] d; logic we; logic [15:0] data; logic [4:0] fl;} vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          n_we = 0;
    logic [15:0] env_rf [8];
    logic [15:0] ref_rf [8];
    logic [15:0] rd_a = '0;
    logic [15:0] rd_b = '0;
    logic [20:0] alu_out;
    cmd_t        expq [$];
    cmd_t        mc;
    logic [20:0] me;
    bit          pend = 0;
    logic [4:0]  pend_flags = '0;
    vec_t        tbl [10];
    int          t0, tw, prev_t, n_we0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dest(cmd_dest),
        .reg_addr_a(reg_addr_a), .reg_addr_b(reg_addr_b), .alu_control(alu_control),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
        .alu_carry(alu_carry), .alu_low(alu_low), .alu_overflow(alu_overflow),
        .alu_neg(alu_neg), .alu_zero(alu_zero), .flags(flags), .busy(busy),
`ifdef ALU_SEQ_OP_COUNT_EN
        .done_pulse(done_pulse), .illegal_op(illegal_op), .op_count(op_count)
`else
        .done_pulse(done_pulse), .illegal_op(illegal_op)
`endif
    );

    // 16-bit ALU: returns {carry, low, overflow, neg, zero, result}; carry is the borrow for subtraction
    function automatic logic [20:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        o;
        s = '0;
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd2, 4'd3, 4'd4: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0];
                c = s[16];
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = a << b[3:0];
            default: r = '0;
        endcase
        return {c, a < b, o, r[15], r == 16'd0, r};
    endfunction

    assign alu_out = alu_f(alu_control, rd_a, rd_b);
    assign {alu_carry, alu_low, alu_overflow, alu_neg, alu_zero} = alu_out[20:16];

    // Synchronous-read regfile environment and cycle counter
    always @(posedge clk) begin
        rd_a <= env_rf[reg_addr_a];
        rd_b <= env_rf[reg_addr_b];
        if (reg_write_en) env_rf[reg_write_addr] <= alu_out[15:0];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: commands retire in push order against a reference register array
    always @(negedge clk) begin
        if (reg_write_en) n_we++;
        if (!reset) begin
            expq.delete();
            pend = 0;
        end else begin
            if (pend) begin
                chk("flags_latch", 32'(flags), 32'(pend_flags));
                pend = 0;
            end
            if (reg_write_en) chk("we_with_done", 32'({reg_write_en, done_pulse}), 32'd3);
            if (illegal_op) begin
                chk("illegal_pending", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    mc = expq.pop_front();
                    chk("illegal_is_undefined", 32'(mc.op > 4'd8), 32'd1);
                    chk("illegal_no_we", 32'(reg_write_en), 32'd0);
                end
            end
            if (done_pulse) begin
                chk("done_pending", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    mc = expq.pop_front();
                    me = alu_f(mc.op, ref_rf[mc.a], ref_rf[mc.b]);
                    chk("done_is_legal", 32'(mc.op <= 4'd8), 32'd1);
                    chk("addr_a", 32'(reg_addr_a), 32'(mc.a));
                    chk("addr_b", 32'(reg_addr_b), 32'(mc.b));
                    chk("alu_ctl", 32'(alu_control), 32'(mc.op));
                    chk("we", 32'(reg_write_en), 32'(mc.op != 4'd4));
                    if (mc.op != 4'd4) begin
                        chk("wr_addr", 32'(reg_write_addr), 32'(mc.d));
                        chk("wr_data", 32'(alu_out[15:0]), 32'(me[15:0]));
                        ref_rf[mc.d] = me[15:0];
                    end
                    pend = 1;
                    pend_flags = me[20:16];
                end
            end
        end
    end

    task automatic push(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b, input logic [2:0] d);
        bit   ok = 0;
        cmd_t nc;
        cmd_op = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dest = d;
        cmd_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("push_accept", 32'(ok), 32'd1);
        nc.op = op;
        nc.a = a;
        nc.b = b;
        nc.d = d;
        if (ok) expq.push_back(nc);
    endtask

    task automatic wait_ev(input bit want_ill, output int at);
        bit hit = 0;
        at = -1;
        for (int n = 0; n < 60 && !hit; n++) begin
            @(negedge clk);
            hit = want_ill ? illegal_op : done_pulse;
        end
        chk(want_ill ? "wait_illegal" : "wait_done", 32'(hit), 32'd1);
        if (hit) at = cyc;
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && (busy || expq.size() != 0); n++) @(negedge clk);
        chk("drain_idle", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        env_rf = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h00F0, 16'h1234};
        ref_rf = env_rf;
        tbl[0] = '{4'd0, 3'd1, 3'd1, 3'd3, 1'b1, 16'h0002, 5'b00000};
        tbl[1] = '{4'd4, 3'd2, 3'd1, 3'd0, 1'b0, 16'h0000, 5'b00010};
        tbl[2] = '{4'hA, 3'd1, 3'd1, 3'd5, 1'b0, 16'h0000, 5'b00010};
        tbl[3] = '{4'd1, 3'd2, 3'd1, 3'd4, 1'b1, 16'h0000, 5'b10001};
        tbl[4] = '{4'd2, 3'd1, 3'd2, 3'd3, 1'b1, 16'h0002, 5'b11000};
        tbl[5] = '{4'd2, 3'd5, 3'd1, 3'd4, 1'b1, 16'h7FFF, 5'b00100};
        tbl[6] = '{4'd5, 3'd6, 3'd7, 3'd0, 1'b1, 16'h0030, 5'b01000};
        tbl[7] = '{4'd7, 3'd7, 3'd7, 3'd4, 1'b1, 16'h0000, 5'b00001};
        tbl[8] = '{4'd8, 3'd1, 3'd7, 3'd3, 1'b1, 16'h0010, 5'b01000};
        tbl[9] = '{4'd6, 3'd6, 3'd7, 3'd0, 1'b1, 16'h12F4, 5'b01000};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_we", 32'(reg_write_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_outs", 32'({reg_addr_a, reg_addr_b, alu_control, reg_write_addr}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // single ADD, cycle by cycle
        push(4'd0, 3'd1, 3'd1, 3'd3);
        t0 = cyc;
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd1);
        chk("t1_idle_we", 32'(reg_write_en), 32'd0);
        @(negedge clk);
        chk("t1_read_addr", 32'({reg_addr_a, reg_addr_b}), 32'({3'd1, 3'd1}));
        chk("t1_read_we", 32'(reg_write_en), 32'd0);
        @(negedge clk);
        chk("t1_exec_ctl", 32'(alu_control), 32'd0);
        chk("t1_exec_we", 32'(reg_write_en), 32'd0);
        @(negedge clk);
        chk("t1_write", 32'({reg_write_en, done_pulse, reg_write_addr}), 32'({1'b1, 1'b1, 3'd3}));
        chk("t1_latency", 32'(cyc - t0), 32'd3);
        @(negedge clk);
        chk("t1_after", 32'({reg_write_en, done_pulse}), 32'd0);
        chk("t1_r3", 32'(env_rf[3]), 32'h0002);

        // vector table
        for (int i = 0; i < 10; i++) begin
            push(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d);
            wait_ev(tbl[i].op > 4'd8, tw);
            if (tbl[i].op <= 4'd8) begin
                chk("tbl_we", 32'(reg_write_en), 32'(tbl[i].we));
                if (tbl[i].we) chk("tbl_data", 32'(alu_out[15:0]), 32'(tbl[i].data));
            end else begin
                chk("tbl_ill_we", 32'(reg_write_en), 32'd0);
            end
            @(negedge clk);
            chk("tbl_flags", 32'(flags), 32'(tbl[i].fl));
        end

        // six back-to-back commands from idle
        fork
            begin
                for (int k = 0; k < 6; k++) push(k < 3 ? 4'(k) : 4'(k + 3), 3'(k + 1), 3'd7, k % 2 == 1 ? 3'd4 : 3'd3);
                chk("b2b_full", 32'(cmd_ready), 32'd0);
            end
            begin
                prev_t = 0;
                for (int k = 0; k < 6; k++) begin
                    wait_ev(1'b0, tw);
                    chk("b2b_we", 32'(reg_write_en), 32'd1);
                    if (k > 0) chk("b2b_spacing", 32'(tw - prev_t), 32'd3);
                    prev_t = tw;
                end
                @(negedge clk);
                chk("b2b_busy_fall", 32'(busy), 32'd0);
            end
        join

        // random commands with random gaps
        for (int i = 0; i < 60; i++) begin
            push($urandom_range(0, 3) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        for (int r = 0; r < 8; r++) chk("rf_final", 32'(env_rf[r]), 32'(ref_rf[r]));

        // reset during EXEC with two commands queued
        @(negedge clk);
        push(4'd0, 3'd1, 3'd2, 3'd3);
        push(4'd1, 3'd1, 3'd2, 3'd4);
        push(4'd5, 3'd1, 3'd2, 3'd5);
        reset = 1'b0;
        #1;
        chk("rst_mid_we", 32'(reg_write_en), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_flags", 32'(flags), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n_we0 = n_we;
        repeat (10) @(negedge clk);
        chk("rst_mid_no_writes", 32'(n_we - n_we0), 32'd0);
        chk("rst_mid_idle", 32'(busy), 32'd0);

        // reset while in WRITE drops the strobe immediately
        push(4'd0, 3'd1, 3'd1, 3'd6);
        wait_ev(1'b0, tw);
        reset = 1'b0;
        #1;
        chk("rst_write_we", 32'(reg_write_en), 32'd0);
        chk("rst_write_done", 32'(done_pulse), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef ALU_SEQ_OP_COUNT_EN
        chk("cnt_reset", 32'(op_count), 32'd0);
        push(4'd0, 3'd1, 3'd1, 3'd3);
        push(4'hB, 3'd1, 3'd1, 3'd3);
        push(4'd4, 3'd1, 3'd2, 3'd0);
        push(4'd7, 3'd1, 3'd2, 3'd4);
        drain();
        chk("cnt_three", 32'(op_count), 32'd3);
        force dut.r_op_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_op_count;
        push(4'd1, 3'd1, 3'd1, 3'd3);
        drain();
        chk("cnt_saturate", 32'(op_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
